// File: rtl/shift_rotate_unit_pkg.sv
// -----------------------------------------------------------------------------
// shift_rotate_pkg
// Shared definitions for the shift/rotate register:
//   - MODE_* : 3-bit operation codes (101..111 are reserved)
//   - state_t: controller states (idle / shifting)
//   - mode_is_valid(): true for the five implemented operation codes
// -----------------------------------------------------------------------------
package shift_rotate_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Reserved codes sit above ROR, so a single compare separates them.
    function automatic logic mode_is_valid(input logic [2:0] m);
        return (m <= MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_rotate_unit_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-bit step of the shift/rotate register.
// Ports:
//   q_in    in  WIDTH  current register value
//   mode    in  3      operation code (see shift_rotate_pkg)
//   q_out   out WIDTH  value after one step
//   bit_out out 1      bit leaving the register on this step
// Reserved codes pass the value through and report a zero bit; the top level
// never steps with a reserved code, so this is only a safe fallback.
// -----------------------------------------------------------------------------
module shift_step
    import shift_rotate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_in,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] q_out,
    output logic             bit_out
);

    // One-position move in the direction and fill selected by mode.
    always_comb begin
        q_out   = q_in;
        bit_out = 1'b0;
        case (mode)
            MODE_SLL: begin
                q_out   = {q_in[WIDTH-2:0], 1'b0};
                bit_out = q_in[WIDTH-1];
            end
            MODE_SRL: begin
                q_out   = {1'b0, q_in[WIDTH-1:1]};
                bit_out = q_in[0];
            end
            MODE_SRA: begin
                q_out   = {q_in[WIDTH-1], q_in[WIDTH-1:1]};
                bit_out = q_in[0];
            end
            MODE_ROL: begin
                q_out   = {q_in[WIDTH-2:0], q_in[WIDTH-1]};
                bit_out = q_in[WIDTH-1];
            end
            MODE_ROR: begin
                q_out   = {q_in[0], q_in[WIDTH-1:1]};
                bit_out = q_in[0];
            end
            default: begin
                q_out   = q_in;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit
// WIDTH-bit register that can be parallel-loaded and then shifted or rotated
// one bit position per clock for a programmable number of steps.
// Ports:
//   clock     in  1      rising-edge clock
//   reset     in  1      synchronous active-high reset (aborts any operation)
//   load      in  1      parallel load request, honoured only when idle
//   load_data in  WIDTH  value loaded into q
//   start     in  1      operation request, honoured only when idle and !load
//   mode      in  3      SLL/SRL/SRA/ROL/ROR (101..111 reserved)
//   amount    in  AMT_W  number of single-bit steps
//   q         out WIDTH  register contents
//   carry     out 1      bit moved out on the last step of the latest operation
//   busy      out 1      high while stepping
//   done      out 1      one-cycle completion pulse
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module shift_rotate_unit
    import shift_rotate_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] AMT_ZERO = AMT_W'(0);
    localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_nxt_s;
    logic [2:0]       mode_r;
    logic [2:0]       mode_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             carry_r;
    logic             carry_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;

    logic [WIDTH-1:0] step_q_s;
    logic             step_bit_s;

    // Steps always use the latched mode so input changes mid-operation are inert.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_in    (q_r),
        .mode    (mode_r),
        .q_out   (step_q_s),
        .bit_out (step_bit_s)
    );

    // Next-state logic: command acceptance in idle, stepping and count-down in shift.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mode_nxt_s  = mode_r;
        q_nxt_s     = q_r;
        carry_nxt_s = carry_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                if (load) begin
                    // Load wins over a simultaneous start; the start is dropped.
                    q_nxt_s = load_data;
                end else if (start) begin
                    mode_nxt_s = mode;
                    if ((amount == AMT_ZERO) || !mode_is_valid(mode)) begin
                        // Nothing to do: report completion with a clear carry.
                        carry_nxt_s = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = amount;
                        state_nxt_s = ST_SHIFT;
                        busy_nxt_s  = 1'b1;
                    end
                end else begin
                    q_nxt_s = q_r;
                end
            end
            ST_SHIFT: begin
                q_nxt_s     = step_q_s;
                carry_nxt_s = step_bit_s;
                cnt_nxt_s   = cnt_r - AMT_ONE;
                if (cnt_r == AMT_ONE) begin
                    // This edge performs the last step.
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_SHIFT;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = AMT_ZERO;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= AMT_ZERO;
            mode_r  <= MODE_SLL;
            q_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            mode_r  <= mode_nxt_s;
            q_r     <= q_nxt_s;
            carry_r <= carry_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign q     = q_r;
    assign carry = carry_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for shift_rotate_unit (WIDTH = 8).
// A reference model predicts, per clock, the visible outputs: when an operation
// is accepted it precomputes the whole trajectory of (q, carry, busy, done)
// with plain arithmetic and queues it; the compare process checks every cycle.
// Directed sequences pin the model with hand-computed values, then random
// stimulus exercises the rest.
// -----------------------------------------------------------------------------
module tb_shift_rotate_unit;

    localparam int W    = 8;
    localparam int AW   = 3;
    localparam int MODV = 256;

    logic          clock;
    logic          reset;
    logic          load;
    logic [W-1:0]  load_data;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic [W-1:0]  q;
    logic          carry;
    logic          busy;
    logic          done;

    int checks;
    int errors;

    typedef struct {
        int q;
        int c;
        int b;
        int d;
    } snap_t;

    snap_t cur;
    snap_t pend[$];
    bit    model_valid;

    shift_rotate_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .q         (q),
        .carry     (carry),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One step of an operation on an 8-bit value, by arithmetic.
    task automatic ref_step(input int m, inout int v, output int c);
        case (m)
            0: begin c = v / 128; v = (v * 2) % MODV; end
            1: begin c = v % 2;   v = v / 2; end
            2: begin c = v % 2;   v = v / 2 + ((v >= 128) ? 128 : 0); end
            3: begin c = v / 128; v = (v * 2) % MODV + c; end
            4: begin c = v % 2;   v = v / 2 + c * 128; end
            default: begin c = 0; end
        endcase
    endtask

    // Advance the model across one rising edge using the inputs being applied.
    task automatic model_edge();
        snap_t s;
        int    v;
        int    c;
        if (reset) begin
            pend.delete();
            cur         = '{0, 0, 0, 0};
            model_valid = 1'b1;
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
        end else if (load) begin
            cur = '{int'(load_data), cur.c, 0, 0};
        end else if (start) begin
            if (amount == 0 || mode > 3'd4) begin
                cur = '{cur.q, 0, 0, 1};
            end else begin
                v = cur.q;
                c = cur.c;
                for (int i = 1; i <= int'(amount); i++) begin
                    ref_step(int'(mode), v, c);
                    s = '{v, c, (i < int'(amount)) ? 1 : 0, (i == int'(amount)) ? 1 : 0};
                    pend.push_back(s);
                end
                cur = '{cur.q, cur.c, 1, 0};
            end
        end else begin
            cur.d = 0;
        end
    endtask

    initial begin
        model_valid = 1'b0;
        forever begin
            @(posedge clock);
            model_edge();
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (model_valid) begin
                check("q", int'(q), cur.q);
                check("carry", int'(carry), cur.c);
                check("busy", int'(busy), cur.b);
                check("done", int'(done), cur.d);
            end
        end
    end

    // Apply one clock's worth of inputs (driven just after a falling edge).
    task automatic cyc(input bit rs, input bit ld, input int ldv,
                       input bit st, input int md, input int am);
        @(negedge clock);
        reset     = rs;
        load      = ld;
        load_data = W'(ldv);
        start     = st;
        mode      = 3'(md);
        amount    = AW'(am);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        load      = 1'b0;
        load_data = '0;
        start     = 1'b0;
        mode      = 3'd0;
        amount    = '0;
        idle(1);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(2);

        // Reset while holding 0xAA.
        cyc(1'b0, 1'b1, 'hAA, 1'b0, 0, 0);
        idle(1);
        check("lit_load_aa", int'(q), 'hAA);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
        idle(1);
        check("lit_rst_q", int'(q), 0);
        check("lit_rst_carry", int'(carry), 0);
        check("lit_rst_busy", int'(busy), 0);
        check("lit_rst_done", int'(done), 0);

        // 0xB4 SRA 3 -> 0xF6, carry 1, busy exactly 3 cycles.
        cyc(1'b0, 1'b1, 'hB4, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 2, 3);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("lit_sra_busy", int'(busy), 1);
            check("lit_sra_nodone", int'(done), 0);
        end
        idle(1);
        check("lit_sra_done", int'(done), 1);
        check("lit_sra_busy_end", int'(busy), 0);
        check("lit_sra_q", int'(q), 'hF6);
        check("lit_sra_carry", int'(carry), 1);

        // 0x81 ROL 4 -> 0x18, carry 0.
        cyc(1'b0, 1'b1, 'h81, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 3, 4);
        idle(5);
        check("lit_rol_q", int'(q), 'h18);
        check("lit_rol_carry", int'(carry), 0);

        // 0x0F SLL 7 -> 0x80, carry 1.
        cyc(1'b0, 1'b1, 'h0F, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 0, 7);
        idle(8);
        check("lit_sll_q", int'(q), 'h80);
        check("lit_sll_carry", int'(carry), 1);

        // Zero amount, then reserved mode: done next cycle, carry cleared.
        cyc(1'b0, 1'b1, 'h3C, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1, 0);
        idle(1);
        check("lit_zero_done", int'(done), 1);
        check("lit_zero_busy", int'(busy), 0);
        check("lit_zero_q", int'(q), 'h3C);
        check("lit_zero_carry", int'(carry), 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 6, 5);
        idle(1);
        check("lit_rsv_done", int'(done), 1);
        check("lit_rsv_busy", int'(busy), 0);
        check("lit_rsv_q", int'(q), 'h3C);
        idle(1);

        // SRL 7 on 0xFF, load ignored while busy, reset on third busy cycle.
        cyc(1'b0, 1'b1, 'hFF, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1, 7);
        cyc(1'b0, 1'b1, 'h55, 1'b0, 0, 0);
        check("lit_srl_busy1", int'(busy), 1);
        cyc(1'b0, 1'b0, 0, 1'b0, 0, 0);
        check("lit_srl_q_after1", int'(q), 'h7F);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 0);
        check("lit_srl_busy3", int'(busy), 1);
        idle(1);
        check("lit_abort_q", int'(q), 0);
        check("lit_abort_busy", int'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            check("lit_abort_nodone", int'(done), 0);
        end

        // Load and start together, then back-to-back ROR 1.
        cyc(1'b0, 1'b1, 'h12, 1'b1, 4, 1);
        idle(1);
        check("lit_ldst_q", int'(q), 'h12);
        check("lit_ldst_busy", int'(busy), 0);
        check("lit_ldst_done", int'(done), 0);
        cyc(1'b0, 1'b0, 0, 1'b1, 4, 1);
        idle(1);
        cyc(1'b0, 1'b0, 0, 1'b1, 4, 1);
        check("lit_b2b_done", int'(done), 1);
        check("lit_b2b_q1", int'(q), 'h09);
        idle(1);
        check("lit_b2b_busy", int'(busy), 1);
        idle(1);
        check("lit_b2b_done2", int'(done), 1);
        check("lit_b2b_q2", int'(q), 'h84);
        check("lit_b2b_carry", int'(carry), 1);

        // Random traffic, including commands during busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int md;
            md = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4))
                                              : int'($urandom_range(0, 7));
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 255)),
                ($urandom_range(0, 2) == 0),
                md,
                int'($urandom_range(0, 7)));
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
# shift_rotate_unit

Parametrised multi-mode shift/rotate register for the lab datapath. It holds a WIDTH-bit value that can be parallel-loaded, then shifted or rotated by a programmable amount, one bit position per clock. A busy/done handshake lets a controller FSM issue commands and wait for completion. It replaces fixed 8-bit, single-step rotate registers with one block covering logical, arithmetic and rotate operations in both directions.

## Interface
- WIDTH, 8, register width in bits; must be at least 2
- AMT_W, $clog2(WIDTH), derived local parameter; width of the shift amount
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load  in  1  parallel-load request; sampled only when idle
- load_data  in  WIDTH  value written to q on an accepted load
- start  in  1  operation request; sampled only when idle
- mode  in  3  operation code: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 reserved
- amount  in  AMT_W  number of single-bit steps (0 to 2^AMT_W−1)
- q  out  WIDTH  register contents
- carry  out  1  bit shifted or rotated out on the last step of the most recent operation
- busy  out  1  high while an operation is executing
- done  out  1  one-cycle pulse when an operation completes

## Operation
- States: IDLE and SHIFT.
  - busy is registered and equals (state == SHIFT).
  - done is a registered pulse.
- IDLE, load=1: q ← load_data; carry unchanged; no done pulse.
  - load has priority over start. If both are asserted, start is dropped.
- IDLE, start=1, load=0: mode and amount are latched.
  - amount=0 or a reserved mode: stay in IDLE; q unchanged; carry ← 0; done=1 in the next cycle.
  - Otherwise: cnt ← amount; go to SHIFT.
- SHIFT: each edge performs one step on q, sets carry to the bit leaving the register, and decrements cnt.
  - When cnt==1, the final step executes, the state returns to IDLE, and done ← 1.
- Step definitions (n = WIDTH−1):
  - SLL: q ← {q[n−1:0], 0}; carry ← q[n]
  - SRL: q ← {0, q[n:1]}; carry ← q[0]
  - SRA: q ← {q[n], q[n:1]}; carry ← q[0]
  - ROL: q ← {q[n−1:0], q[n]}; carry ← q[n]
  - ROR: q ← {q[0], q[n:1]}; carry ← q[0]
- Amounts of WIDTH or more are executed literally, one step per count; they are not reduced modulo WIDTH. Example: SLL by ≥ WIDTH yields 0.
- load and start are ignored while busy. Changes to mode and amount during SHIFT have no effect.
- reset, at any time including mid-operation: q ← 0, carry ← 0, busy ← 0, done ← 0, state ← IDLE, cnt ← 0. No done pulse is produced for an aborted operation.

## Timing
- Reset values: q = 0, carry = 0, busy = 0, done = 0.
- Load latency: q shows load_data in the cycle after the load edge.
- Shift latency: start accepted at edge E0 with amount k ≥ 1.
  - busy is high for exactly k cycles, after edges E0 through E(k−1).
  - q changes at edges E1 through Ek.
  - done is high for exactly one cycle, after edge Ek, with busy = 0 and the final q and carry valid.
- Zero-amount or reserved-mode latency: done is high in the cycle after the start edge; busy never rises.
- A new start or load is accepted on the same edge on which done is high (back-to-back operation).
- Outputs are registers only; no combinational path from inputs to outputs.

## Structure
- Shared package shift_rotate_pkg:
  - mode constants MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR
  - state enum {ST_IDLE, ST_SHIFT}
- One combinational sub-module, shift_step: inputs q_in and mode; outputs q_out and bit_out.
  - It implements a single-bit step. The top level holds the FSM, the counter and the registers.

## Test plan
- Reset while loaded with 0xAA → next cycle q=0x00, carry=0, busy=0, done=0.
- Load 0xB4, then SRA amount 3 → busy for 3 cycles, then done pulse with q=0xF6, carry=1.
- Load 0x81, then ROL amount 4 → q=0x18, carry=0. Load 0x0F, then SLL amount 7 → q=0x80, carry=1.
- Load 0x3C, then start with amount 0 → done in the next cycle, q=0x3C, carry=0, busy never high. Repeat with mode 110 → same result.
- SRL amount 7 on 0xFF; assert load=1 with 0x55 during busy → load ignored. Assert reset on the third busy cycle → next cycle q=0x00, busy=0, and no done ever appears.
- In IDLE, assert load (0x12) and start (ROR, amount 1) together → q=0x12, no busy, no done. Then issue ROR 1 on the done edge of a prior operation → accepted back-to-back.
